// File: rtl/sync_event_pkg.sv
// Shared constants and helpers for the synchronized-event arbiter.
// Combinational helpers only; no state, no latency, no backpressure.
package sync_event_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    // Ones count over up to 16 channels; narrower vectors are zero-extended by the caller.
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // count + incr, clamped to the largest value a cnt_w-bit counter can hold.
    function automatic logic [31:0] sat_add(input logic [31:0] count,
                                            input logic [31:0] incr,
                                            input int          cnt_w);
        logic [32:0] sum;
        logic [31:0] lim;
        sum = {1'b0, count} + {1'b0, incr};
        lim = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
        return (sum[32] || (sum[31:0] > lim)) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N_CH.
// Purely combinational (zero latency); no handshake, the caller decides when to apply it.
// Rotates req so bit ptr+1 lands at 0, priority-encodes, then maps the index back.
module rr_picker #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            any,
    output logic [CH_W-1:0] idx
);

    logic [N_CH-1:0] rot;
    int              first;

    always_comb begin
        rot = '0;
        for (int k = 0; k < N_CH; k++) begin
            rot[k] = req[CH_W'((int'(ptr) + 1 + k) % N_CH)];
        end
    end

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        first = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) first = k;
        end
    end

    assign any = |rot;
    assign idx = CH_W'((int'(ptr) + 1 + first) % N_CH);

endmodule

// File: rtl/sync_event_arbiter.sv
// Serializes per-channel event strobes onto one valid/ready output, round-robin, with drop stats.
// Latency: a pulse into a free slot is presented the next cycle; one event per cycle with out_ready high.
// Backpressure: out_valid && !out_ready freezes out_chan and the pointer; new pulses wait in pending.
module sync_event_arbiter
    import sync_event_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  event_pulse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_chan,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  overflow,
    output logic [CNT_W-1:0] drop_count,
    input  logic             clear_stats
);

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] drop;
    logic [N_CH-1:0] pending_next;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] pick_idx;
    logic            pick_any;
    logic            slot_free;
    logic            do_grant;
    logic [31:0]     drop_incr;

    // Fresh pulses join the request set so they can be served in their arrival cycle.
    assign req       = pending | event_pulse;
    assign slot_free = ~out_valid | out_ready;
    assign do_grant  = slot_free & pick_any;
    assign grant     = do_grant ? (N_CH'(1) << pick_idx) : '0;

    // A channel granted while pulsing again keeps the new pulse pending.
    assign pending_next = (pending & (~grant | event_pulse)) |
                          (~pending & event_pulse & ~grant);
    assign drop         = pending & event_pulse & ~grant;
    assign drop_incr    = 32'(popcount(16'(drop)));

    rr_picker #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_picker (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            ptr       <= CH_W'(N_CH - 1);
            pending   <= '0;
        end else begin
            pending <= pending_next;
            if (slot_free) begin
                out_valid <= pick_any;
                if (pick_any) begin
                    out_chan <= pick_idx;
                    ptr      <= pick_idx;
                end
            end
        end
    end

    // Drops landing in the clearing cycle are kept rather than lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= '0;
            drop_count <= '0;
        end else if (clear_stats) begin
            overflow   <= drop;
            drop_count <= CNT_W'(sat_add(32'd0, drop_incr, CNT_W));
        end else begin
            overflow   <= overflow | drop;
            drop_count <= CNT_W'(sat_add(32'(drop_count), drop_incr, CNT_W));
        end
    end

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: directed vector table, corner-case sequences and random stimulus vs a reference model.
module tb_sync_event_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] event_pulse;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [7:0] drop_count;
    logic       clear_stats;

    int n_cmp = 0;
    int n_err = 0;

    sync_event_arbiter #(.N_CH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .event_pulse (event_pulse),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .pending     (pending),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .clear_stats (clear_stats)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: a set of waiting events, one presented slot, a last-served index, a clamped tally.
    bit [3:0] m_pend, m_ovf;
    bit       m_v;
    int       m_chan, m_ptr, m_cnt;

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_v = 0; m_chan = 0; m_ptr = N - 1; m_cnt = 0;
    endtask

    task automatic model_step(input bit [3:0] ev, input bit rdy, input bit clr);
        bit [3:0] req, g, lost;
        bit       found;
        int       idx, pop;
        req = m_pend | ev;
        g = '0;
        if (!m_v || rdy) begin
            found = 0;
            for (int s = 1; s <= N; s++) begin
                idx = (m_ptr + s) % N;
                if (!found && req[idx]) begin
                    found = 1; g[idx] = 1'b1; m_chan = idx; m_ptr = idx;
                end
            end
            m_v = found;
        end
        lost = m_pend & ev & ~g;
        pop = 0;
        for (int i = 0; i < N; i++) begin
            pop += int'(lost[i]);
            if (g[i]) m_pend[i] = m_pend[i] & ev[i];
            else      m_pend[i] = m_pend[i] | ev[i];
        end
        if (clr) begin
            m_ovf = lost; m_cnt = pop;
        end else begin
            m_ovf = m_ovf | lost;
            m_cnt = (m_cnt + pop > 255) ? 255 : m_cnt + pop;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"},    32'(out_valid),  32'(m_v));
        if (m_v) chk({tag, ".chan"}, 32'(out_chan), 32'(m_chan));
        chk({tag, ".pending"},  32'(pending),    32'(m_pend));
        chk({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
        chk({tag, ".drops"},    32'(drop_count), 32'(m_cnt));
    endtask

    // Apply one cycle of inputs (driven #1 after an edge), clock it, land #1 after the next edge.
    task automatic cyc(input logic [3:0] ev, input logic rdy, input logic clr);
        event_pulse = ev; out_ready = rdy; clear_stats = clr;
        model_step(ev, rdy, clr);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        event_pulse = '0; out_ready = 1'b0; clear_stats = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] ev;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] ch;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[21];
    int   gcount[4];
    logic [3:0] ones;

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[1]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1101, 4'b0000, 8'd0};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1001, 4'b0000, 8'd0};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b0000, 8'd0};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 8'd0};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 8'd0};
        tbl[9]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 4'b0000, 8'd0};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 4'b0000, 8'd0};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 4'b0000, 8'd0};
        tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 4'b0010, 8'd1};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 8'd1};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0010, 8'd1};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0};
        tbl[16] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 8'd0};
        tbl[17] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 8'd0};
        tbl[18] = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 8'd0};
        tbl[19] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 8'd0};
        tbl[20] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 8'd0};

        // Reset values while reset is held.
        event_pulse = '0; out_ready = 1'b0; clear_stats = 1'b0; reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("rst.valid",    32'(out_valid),  0);
        chk("rst.chan",     32'(out_chan),   0);
        chk("rst.pending",  32'(pending),    0);
        chk("rst.overflow", 32'(overflow),   0);
        chk("rst.drops",    32'(drop_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vector table.
        for (int r = 0; r < 21; r++) begin
            cyc(tbl[r].ev, tbl[r].rdy, tbl[r].clr);
            chk($sformatf("vec%0d.valid", r),    32'(out_valid),  32'(tbl[r].v));
            chk($sformatf("vec%0d.chan", r),     32'(out_chan),   32'(tbl[r].ch));
            chk($sformatf("vec%0d.pending", r),  32'(pending),    32'(tbl[r].pend));
            chk($sformatf("vec%0d.overflow", r), 32'(overflow),   32'(tbl[r].ovf));
            chk($sformatf("vec%0d.drops", r),    32'(drop_count), 32'(tbl[r].cnt));
        end

        // All channels pulsing every cycle: strict rotation, three grants each, 32 drops total.
        do_reset();
        for (int c = 0; c < 4; c++) gcount[c] = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            chk($sformatf("rot%0d.chan", k), 32'(out_chan), 32'(k % 4));
            chk_model($sformatf("rot%0d", k));
            if (out_valid) gcount[out_chan]++;
        end
        for (int c = 0; c < 4; c++) chk($sformatf("rot.grants_ch%0d", c), 32'(gcount[c]), 3);
        chk("rot.total_drops", 32'(drop_count), 32);

        // Saturation: ch3 held pending behind a stalled ch0, then pulsed 300 times.
        do_reset();
        cyc(4'b0001, 1'b1, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++) cyc(4'b1000, 1'b0, 1'b0);
        chk("sat.at255", 32'(drop_count), 255);
        for (int k = 0; k < 45; k++) cyc(4'b1000, 1'b0, 1'b0);
        chk("sat.hold255", 32'(drop_count), 255);
        chk("sat.overflow", 32'(overflow), 32'b1000);
        chk_model("sat");
        cyc(4'b1000, 1'b0, 1'b1);
        chk("clr.drops", 32'(drop_count), 1);
        chk("clr.overflow", 32'(overflow), 32'b1000);
        chk("clr.pending_kept", 32'(pending), 32'b1000);
        chk("clr.valid_kept", 32'(out_valid), 1);

        // Reset mid-transaction clears outputs before the next edge.
        do_reset();
        cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0110, 1'b0, 1'b0);
        chk("mid.pre_valid", 32'(out_valid), 1);
        chk("mid.pre_pending", 32'(pending), 32'b0110);
        event_pulse = '0;
        reset = 1'b1;
        #1;
        chk("mid.valid", 32'(out_valid), 0);
        chk("mid.chan", 32'(out_chan), 0);
        chk("mid.pending", 32'(pending), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        ones = 4'b1111;
        cyc(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst%0d.valid", k), 32'(out_valid), 1);
            chk($sformatf("burst%0d.chan", k), 32'(out_chan), 32'(k));
            chk($sformatf("burst%0d.pending", k), 32'(pending), 32'(4'(ones << (k + 1))));
            cyc(4'b0000, 1'b1, 1'b0);
        end
        chk("burst.idle", 32'(out_valid), 0);
        chk("burst.drops", 32'(drop_count), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            cyc(4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            chk_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_event_arbiter.md
Name: sync_event_arbiter

Overview:
Collects single-cycle event strobes from N_CH clock-domain synchronizers, all already in the clk domain. Holds one pending flag per channel. Serializes the pending events to a single downstream consumer through a valid/ready handshake, using round-robin arbitration. Tracks events lost because a channel fired again before its previous event was granted; these statistics are for debug and status registers.

Parameters:
N_CH, 4, number of synchronized event channels (2..16)
CNT_W, 8, width of the saturating drop counter
CH_W, $clog2(N_CH), width of the channel index (derived, not overridable)

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  asynchronous, active-high reset
event_pulse  input  N_CH  one-cycle strobes, one per synchronizer output
out_valid  output  1  a granted event is presented on out_chan
out_ready  input  1  consumer accepts the presented event this cycle
out_chan  output  CH_W  channel index of the presented event
pending  output  N_CH  registered per-channel pending flags
overflow  output  N_CH  sticky per-channel drop flags
drop_count  output  CNT_W  total dropped events, saturating
clear_stats  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset values (asynchronous, on reset=1):
  - out_valid=0, out_chan=0, pending=0, overflow=0, drop_count=0.
  - Internal round-robin pointer ptr=N_CH-1, so channel 0 has first priority after reset.
- Request vector: req = pending | event_pulse. This allows a fresh pulse to be granted in the same cycle it arrives.
- Output slot free: slot_free = ~out_valid | out_ready.
- Grant, when slot_free and req!=0:
  - idx = first set bit of req, searching ptr+1, ptr+2, ... and wrapping modulo N_CH.
  - Next edge: out_valid<=1, out_chan<=idx, ptr<=idx.
  - grant = onehot(idx); otherwise grant=0.
- When slot_free and req==0: out_valid<=0; out_chan and ptr hold.
- When out_valid=1 and out_ready=0: out_valid, out_chan and ptr hold, so out_chan is stable while valid. No grant occurs in that cycle.
- Latency: a pulse at cycle t with the slot free and no competing request gives out_valid=1 at t+1. Minimum spacing between accepted events is 1 cycle, giving full throughput with out_ready held high.
- Pending update, per channel i:
  - pending_next[i] = pending[i] ? (~grant[i] | event_pulse[i]) : (event_pulse[i] & ~grant[i]).
  - If a pending channel is granted in the same cycle it pulses again, the new pulse stays pending and nothing is lost.
- Drop condition: drop[i] = pending[i] & event_pulse[i] & ~grant[i].
  - On drop, overflow[i]<=1.
  - drop_count<=min(drop_count + popcount(drop), 2^CNT_W-1).
- clear_stats=1:
  - overflow<=drop and drop_count<=popcount(drop). Drops in the clearing cycle are counted, not discarded.
  - clear_stats does not affect pending, out_valid or ptr.
- The event held in the output register is independent of pending. A channel can be presented on out_chan and pending again at the same time.
- Reset asserted mid-transaction discards the presented event and all pending events immediately. No output is produced until reset deasserts and a new pulse arrives.
- event_pulse bits are assumed to be single-cycle strobes. A level held high for k cycles is treated as k events, so it may record drops.

Decomposition:
- Package sync_event_pkg holds:
  - default constants N_CH_DEF=4 and CNT_W_DEF=8;
  - function popcount(N_CH bits);
  - function sat_add(count, incr) for the saturating add.
- Sub-module rr_picker (combinational):
  - inputs req[N_CH] and ptr[CH_W];
  - outputs any and idx[CH_W];
  - implemented as rotate, then priority-encode, then un-rotate.
- All state (the output register, pending, ptr and statistics) stays in sync_event_arbiter.

Test Plan:
1. Reset, then event_pulse=4'b0001 at cycle 5 with out_ready=1 -> out_valid=1, out_chan=0 at cycle 6 only; pending stays 0; drop_count=0.
2. event_pulse=4'b1111 in one cycle, out_ready=1 -> out_chan=0,1,2,3 on 4 consecutive cycles; pending goes 1110 -> 1100 -> 1000 -> 0000; no drops.
3. out_ready=0 with ch2 presented; pulse ch1 twice, 3 cycles apart -> out_chan stays 2; overflow=4'b0010; drop_count=1. Then raise out_ready -> ch1 presented next, exactly once.
4. All channels pulsing every cycle with out_ready=1 for 12 cycles -> grants rotate 0,1,2,3,0,...; each channel is granted 3 times; drop_count increments by popcount(drops) each cycle.
5. 300 drops with CNT_W=8 -> drop_count saturates at 255. Then clear_stats coincident with one drop on ch3 -> drop_count=1, overflow=4'b1000.
6. Assert reset while out_valid=1 and pending=4'b0110 -> all outputs 0 immediately (before the next edge); after release, the first grant goes to channel 0 when all channels pulse together.
